mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Opcode constants and FSM state encoding shared by the memory access unit files.
package mem_pkg;

    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive unanswered memory wait cycles and flags the cycle in which
// the TIMEOUT_CYCLES-th wait occurs. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_wait,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // r_count holds the waits already seen, so the current wait is number r_count+1.
    assign o_expire_c = i_wait && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_wait && !o_expire_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: retires ALU results in one cycle and runs LW/SW through a
// request/ready handshake. Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES waits.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_store_data,
    input  logic [3:0]  ex_dst_reg,
    input  logic        ex_wr_en,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_reg,
    output logic        mem_err
);

    state_t     r_state;
    logic [3:0] r_dst;
    logic       w_accept_mem;
    logic       w_wait;
    logic       w_timeout;

    assign w_accept_mem = (r_state == S_IDLE) && ex_valid && is_mem_op(ex_opcode);
    assign w_wait       = (r_state == S_BUSY) && !mem_ready;

    // A timed-out access retires this cycle, so upstream is released with it.
    assign stall = w_accept_mem || (w_wait && !w_timeout);

`ifdef MEM_TIMEOUT_EN
    logic r_mem_err;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept_mem),
        .i_wait    (w_wait),
        .o_expire_c(w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (w_timeout) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign mem_err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dst     <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_en     <= 1'b0;
            wb_data   <= '0;
            wb_reg    <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept_mem) begin
                        r_state   <= S_BUSY;
                        r_dst     <= ex_dst_reg;
                        mem_req   <= 1'b1;
                        mem_wr    <= (ex_opcode == OP_SW);
                        mem_addr  <= ex_alu_out;
                        mem_wdata <= ex_store_data;
                    end else if (ex_valid) begin
                        wb_valid <= 1'b1;
                        wb_en    <= ex_wr_en;
                        wb_data  <= ex_alu_out;
                        wb_reg   <= ex_dst_reg;
                    end
                end
                S_BUSY: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (mem_ready) begin
                        r_state  <= S_IDLE;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_en    <= !mem_wr;
                        wb_reg   <= r_dst;
                        if (!mem_wr) begin
                            wb_data <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_en    <= 1'b0;
                        wb_reg   <= r_dst;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized
// instruction stream checked against expected writebacks derived from each instruction.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 64;
`endif
    localparam int unsigned WMAX = (TO - 1 < 4) ? TO - 1 : 4;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_wr_en, mem_ready;
    logic [3:0]  ex_opcode, ex_dst_reg;
    logic [15:0] ex_alu_out, ex_store_data, mem_rdata;
    logic        mem_req, mem_wr, stall, wb_valid, wb_en, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  wb_reg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_dst_reg(ex_dst_reg),
        .ex_wr_en(ex_wr_en), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_data(wb_data), .wb_reg(wb_reg), .mem_err(mem_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_opcode = 4'd0; ex_alu_out = 16'd0; ex_store_data = 16'd0;
        ex_dst_reg = 4'd0; ex_wr_en = 1'b0; mem_ready = 1'b0; mem_rdata = 16'd0;
    endtask

    function automatic logic [3:0] rand_alu_op();
        logic [3:0] op;
        op = 4'($urandom_range(0, 13));
        if (op >= 4'd8) op = op + 4'd2;
        return op;
    endfunction

    task automatic test_reset();
        idle_in();
        rst = 1'b1; ex_valid = 1'b1; ex_opcode = OP_LW; mem_ready = 1'b1; mem_rdata = 16'($urandom);
        step(); step();
        n_cmp++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== 34'd0) begin
            n_err++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_req, mem_wr, mem_addr, mem_wdata}); end
        n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg} !== 22'd0) begin
            n_err++; $display("FAIL reset_wb: got %h expected 0", {wb_valid, wb_en, wb_data, wb_reg}); end
        n_cmp++; if (mem_err !== 1'b0) begin
            n_err++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
        rst = 1'b0; ex_valid = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
        step();
        n_cmp++; if ({mem_req, wb_valid} !== 2'b00) begin
            n_err++; $display("FAIL idle_ready_ignored: got req/wbv %b expected 00", {mem_req, wb_valid}); end
    endtask

    task automatic test_alu();
        logic [15:0] a;
        logic [3:0]  d, op;
        logic        e;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                op = OP_ADD; a = 16'h1234; d = 4'd3; e = 1'b1;
            end else begin
                op = rand_alu_op(); a = 16'($urandom); d = 4'($urandom); e = 1'($urandom);
            end
            ex_valid = 1'b1; ex_opcode = op; ex_alu_out = a; ex_dst_reg = d; ex_wr_en = e;
            ex_store_data = 16'($urandom); mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
            #1;
            n_cmp++; if (stall !== 1'b0) begin
                n_err++; $display("FAIL alu_stall[%0d]: got %b expected 0", i, stall); end
            step();
            n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg} !== {1'b1, e, a, d}) begin
                n_err++; $display("FAIL alu_wb[%0d]: got %h expected %h", i,
                                  {wb_valid, wb_en, wb_data, wb_reg}, {1'b1, e, a, d}); end
            n_cmp++; if (mem_req !== 1'b0) begin
                n_err++; $display("FAIL alu_mem_req[%0d]: got %b expected 0", i, mem_req); end
            if (i % 3 == 2) begin
                idle_in(); mem_ready = 1'($urandom);
                step();
                n_cmp++; if (wb_valid !== 1'b0) begin
                    n_err++; $display("FAIL alu_bubble[%0d]: got wb_valid %b expected 0", i, wb_valid); end
            end
        end
        idle_in();
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        ex_valid = 1'b1; ex_opcode = OP_LW; ex_alu_out = 16'h0040; ex_dst_reg = 4'd7;
        ex_wr_en = 1'b0; ex_store_data = 16'($urandom); mem_ready = 1'b0;
        #1; if (stall) stall_cnt++;
        step();
        n_cmp++; if ({mem_req, mem_wr, mem_addr, wb_valid} !== {1'b1, 1'b0, 16'h0040, 1'b0}) begin
            n_err++; $display("FAIL lw_request: got %h expected %h",
                              {mem_req, mem_wr, mem_addr, wb_valid}, {1'b1, 1'b0, 16'h0040, 1'b0}); end
        for (int c = 0; c < 3; c++) begin
            ex_opcode = 4'($urandom); ex_alu_out = 16'($urandom); mem_ready = 1'b0;
            #1; if (stall) stall_cnt++;
            step();
            n_cmp++; if ({mem_req, mem_addr, wb_valid} !== {1'b1, 16'h0040, 1'b0}) begin
                n_err++; $display("FAIL lw_wait[%0d]: got %h expected %h", c,
                                  {mem_req, mem_addr, wb_valid}, {1'b1, 16'h0040, 1'b0}); end
        end
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        #1; if (stall) stall_cnt++;
        step();
        n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg, mem_req} !== {1'b1, 1'b1, 16'hBEEF, 4'd7, 1'b0}) begin
            n_err++; $display("FAIL lw_retire: got %h expected %h",
                              {wb_valid, wb_en, wb_data, wb_reg, mem_req}, {1'b1, 1'b1, 16'hBEEF, 4'd7, 1'b0}); end
        n_cmp++; if (stall_cnt !== 4) begin
            n_err++; $display("FAIL lw_stall_cycles: got %0d expected 4", stall_cnt); end
        idle_in();
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL lw_pulse: got wb_valid %b expected 0", wb_valid); end
    endtask

    task automatic test_store();
        ex_valid = 1'b1; ex_opcode = OP_SW; ex_alu_out = 16'h0010; ex_store_data = 16'hA5A5;
        ex_dst_reg = 4'($urandom); ex_wr_en = 1'b1; mem_ready = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin
            n_err++; $display("FAIL sw_accept_stall: got %b expected 1", stall); end
        step();
        n_cmp++; if ({mem_req, mem_wr, mem_addr, mem_wdata, wb_valid} !== {1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0}) begin
            n_err++; $display("FAIL sw_request: got %h expected %h",
                              {mem_req, mem_wr, mem_addr, mem_wdata, wb_valid}, {1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0}); end
        idle_in(); mem_ready = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin
            n_err++; $display("FAIL sw_ready_stall: got %b expected 0", stall); end
        step();
        n_cmp++; if ({wb_valid, wb_en, mem_req} !== 3'b100) begin
            n_err++; $display("FAIL sw_retire: got %b expected 100", {wb_valid, wb_en, mem_req}); end
        idle_in();
        step();
    endtask

    task automatic test_back_to_back();
        int          wb_cnt = 0;
        int          req_rise = 0;
        logic        prev_req = 1'b0;
        logic [15:0] addr, rd, a2;
        logic [3:0]  d1, d2;
        addr = 16'($urandom) & 16'hFFFE; rd = 16'($urandom); a2 = 16'($urandom);
        d1 = 4'($urandom); d2 = 4'($urandom);
        ex_valid = 1'b1; ex_opcode = OP_LW; ex_alu_out = addr; ex_dst_reg = d1;
        ex_wr_en = 1'b0; ex_store_data = 16'($urandom);
        for (int c = 0; c < 5; c++) begin
            mem_ready = (c >= 2);
            mem_rdata = (c == 2) ? rd : 16'($urandom);
            if (c == 3) begin
                ex_opcode = OP_ADD; ex_alu_out = a2; ex_dst_reg = d2; ex_wr_en = 1'b1;
            end
            if (c == 4) idle_in();
            #1;
            n_cmp++; if (stall !== (c < 2)) begin
                n_err++; $display("FAIL b2b_stall[%0d]: got %b expected %b", c, stall, (c < 2)); end
            step();
            if (wb_valid) wb_cnt++;
            if (mem_req && !prev_req) req_rise++;
            prev_req = mem_req;
            if (c == 2) begin
                n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg} !== {1'b1, 1'b1, rd, d1}) begin
                    n_err++; $display("FAIL b2b_lw_wb: got %h expected %h",
                                      {wb_valid, wb_en, wb_data, wb_reg}, {1'b1, 1'b1, rd, d1}); end
            end
            if (c == 3) begin
                n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg, mem_req} !== {1'b1, 1'b1, a2, d2, 1'b0}) begin
                    n_err++; $display("FAIL b2b_add_wb: got %h expected %h",
                                      {wb_valid, wb_en, wb_data, wb_reg, mem_req}, {1'b1, 1'b1, a2, d2, 1'b0}); end
            end
        end
        n_cmp++; if (wb_cnt !== 2) begin
            n_err++; $display("FAIL b2b_retire_count: got %0d expected 2", wb_cnt); end
        n_cmp++; if (req_rise !== 1) begin
            n_err++; $display("FAIL b2b_request_count: got %0d expected 1", req_rise); end
    endtask

    task automatic test_reset_busy();
        logic [15:0] a;
        logic [3:0]  d;
        ex_valid = 1'b1; ex_opcode = OP_LW; ex_alu_out = 16'($urandom); ex_dst_reg = 4'($urandom);
        mem_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; idle_in();
        n_cmp++; if ({mem_req, wb_valid} !== 2'b00) begin
            n_err++; $display("FAIL rstbusy_outputs: got req/wbv %b expected 00", {mem_req, wb_valid}); end
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1; mem_rdata = 16'($urandom);
            #1;
            n_cmp++; if (stall !== 1'b0) begin
                n_err++; $display("FAIL rstbusy_stall[%0d]: got %b expected 0", c, stall); end
            step();
            n_cmp++; if ({mem_req, wb_valid} !== 2'b00) begin
                n_err++; $display("FAIL rstbusy_late_ready[%0d]: got req/wbv %b expected 00", c, {mem_req, wb_valid}); end
        end
        a = 16'($urandom); d = 4'($urandom);
        ex_valid = 1'b1; ex_opcode = OP_ADD; ex_alu_out = a; ex_dst_reg = d; ex_wr_en = 1'b1; mem_ready = 1'b0;
        step();
        n_cmp++; if ({wb_valid, wb_data, wb_reg} !== {1'b1, a, d}) begin
            n_err++; $display("FAIL rstbusy_idle_alu: got %h expected %h", {wb_valid, wb_data, wb_reg}, {1'b1, a, d}); end
        idle_in();
        step();
    endtask

    task automatic test_random();
        int          kind, w;
        logic [15:0] a, sd, rd;
        logic [3:0]  d;
        logic        e;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            a = 16'($urandom); sd = 16'($urandom); rd = 16'($urandom);
            d = 4'($urandom); e = 1'($urandom);
            if (kind == 0) begin
                idle_in(); mem_ready = 1'($urandom);
                #1;
                n_cmp++; if (stall !== 1'b0) begin
                    n_err++; $display("FAIL rnd_bubble_stall[%0d]: got %b expected 0", n, stall); end
                step();
                n_cmp++; if ({wb_valid, mem_req} !== 2'b00) begin
                    n_err++; $display("FAIL rnd_bubble[%0d]: got %b expected 00", n, {wb_valid, mem_req}); end
            end else if (kind == 1) begin
                ex_valid = 1'b1; ex_opcode = rand_alu_op(); ex_alu_out = a; ex_dst_reg = d;
                ex_wr_en = e; ex_store_data = sd; mem_ready = 1'($urandom);
                step();
                n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg} !== {1'b1, e, a, d}) begin
                    n_err++; $display("FAIL rnd_alu[%0d]: got %h expected %h", n,
                                      {wb_valid, wb_en, wb_data, wb_reg}, {1'b1, e, a, d}); end
            end else begin
                w = int'($urandom_range(0, WMAX));
                ex_valid = 1'b1; ex_opcode = (kind == 3) ? OP_SW : OP_LW; ex_alu_out = a;
                ex_dst_reg = d; ex_wr_en = e; ex_store_data = sd; mem_ready = 1'($urandom);
                #1;
                n_cmp++; if (stall !== 1'b1) begin
                    n_err++; $display("FAIL rnd_accept_stall[%0d]: got %b expected 1", n, stall); end
                for (int c = 0; c <= w; c++) begin
                    step();
                    n_cmp++; if ({mem_req, mem_wr, mem_addr, mem_wdata, wb_valid} !== {1'b1, kind == 3, a, sd, 1'b0}) begin
                        n_err++; $display("FAIL rnd_mem_bus[%0d.%0d]: got %h expected %h", n, c,
                                          {mem_req, mem_wr, mem_addr, mem_wdata, wb_valid}, {1'b1, kind == 3, a, sd, 1'b0}); end
                    ex_opcode = 4'($urandom); ex_alu_out = 16'($urandom); ex_store_data = 16'($urandom);
                    mem_ready = (c == w); mem_rdata = (c == w) ? rd : 16'($urandom);
                    #1;
                    n_cmp++; if (stall !== (c != w)) begin
                        n_err++; $display("FAIL rnd_busy_stall[%0d.%0d]: got %b expected %b", n, c, stall, (c != w)); end
                end
                step();
                if (kind == 2) begin
                    n_cmp++; if ({wb_valid, wb_en, wb_data, wb_reg, mem_req} !== {1'b1, 1'b1, rd, d, 1'b0}) begin
                        n_err++; $display("FAIL rnd_lw_retire[%0d]: got %h expected %h", n,
                                          {wb_valid, wb_en, wb_data, wb_reg, mem_req}, {1'b1, 1'b1, rd, d, 1'b0}); end
                end else begin
                    n_cmp++; if ({wb_valid, wb_en, mem_req} !== 3'b100) begin
                        n_err++; $display("FAIL rnd_sw_retire[%0d]: got %b expected 100", n, {wb_valid, wb_en, mem_req}); end
                end
            end
            n_cmp++; if (mem_err !== 1'b0) begin
                n_err++; $display("FAIL rnd_mem_err[%0d]: got %b expected 0", n, mem_err); end
        end
        idle_in();
        step();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] d;
        d = 4'($urandom);
        ex_valid = 1'b1; ex_opcode = OP_LW; ex_alu_out = 16'($urandom); ex_dst_reg = d; mem_ready = 1'b0;
        step();
        idle_in();
        for (int c = 1; c <= int'(TO); c++) begin
            #1;
            if (c < int'(TO)) begin
                n_cmp++; if (stall !== 1'b1) begin
                    n_err++; $display("FAIL to_wait_stall[%0d]: got %b expected 1", c, stall); end
            end
            step();
            if (c < int'(TO)) begin
                n_cmp++; if ({mem_req, wb_valid, mem_err} !== 3'b100) begin
                    n_err++; $display("FAIL to_waiting[%0d]: got %b expected 100", c, {mem_req, wb_valid, mem_err}); end
            end else begin
                n_cmp++; if ({mem_req, wb_valid, wb_en, mem_err} !== 4'b0101) begin
                    n_err++; $display("FAIL to_abort: got %b expected 0101", {mem_req, wb_valid, wb_en, mem_err}); end
            end
        end
        ex_valid = 1'b1; ex_opcode = OP_ADD; ex_wr_en = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if ({wb_valid, mem_err} !== 2'b11) begin
                n_err++; $display("FAIL to_sticky[%0d]: got %b expected 11", c, {wb_valid, mem_err}); end
        end
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (mem_err !== 1'b0) begin
            n_err++; $display("FAIL to_clear_on_reset: got %b expected 0", mem_err); end
    endtask
`endif

    initial begin
        idle_in();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_busy();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
